// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl
//   Key-entry sequencer for the keypad calculator. It turns keypad presses into
//   two BCD operands plus an add/subtract operator. On '=' it raises a
//   calculation request and waits for the datapath. It then holds the
//   result-display state until the next key arrives.
//
// Ports
//   i_clk              system clock, everything on posedge
//   i_rst              synchronous active-high reset
//   i_press            key-held level from the scanner
//   i_scan_code        key code, valid while i_press=1 (0-9 digits, A..F commands)
//   i_calc_ack         datapath done, sampled only in CALC
//   o_buf_flag_1/2     operand digit-occupied flags (thermometer, LSB first)
//   o_key_buf_code_1/2 operand BCD, newest digit in [3:0]
//   o_op_sub           0 = add, 1 = subtract
//   o_calc_req         calculation request, held until ack
//   o_result_valid     datapath result is being displayed
//   o_err              one-cycle pulse on the cycle after a rejected key
//   o_state            00 ENTER_A, 01 ENTER_B, 10 CALC, 11 RESULT
module calc_entry_ctrl #(
   parameter int unsigned DIGITS  = 6,
   parameter logic [3:0]  KEY_ADD = 4'hA,
   parameter logic [3:0]  KEY_SUB = 4'hB,
   parameter logic [3:0]  KEY_EQ  = 4'hC,
   parameter logic [3:0]  KEY_BS  = 4'hD,
   parameter logic [3:0]  KEY_CE  = 4'hE,
   parameter logic [3:0]  KEY_AC  = 4'hF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_press,
   input  logic [3:0]            i_scan_code,
   input  logic                  i_calc_ack,
   output logic [DIGITS-1:0]     o_buf_flag_1,
   output logic [4*DIGITS-1:0]   o_key_buf_code_1,
   output logic [DIGITS-1:0]     o_buf_flag_2,
   output logic [4*DIGITS-1:0]   o_key_buf_code_2,
   output logic                  o_op_sub,
   output logic                  o_calc_req,
   output logic                  o_result_valid,
   output logic                  o_err,
   output logic [1:0]            o_state
);

   localparam int unsigned CW = 4 * DIGITS;

   typedef enum logic [1:0] {
      ENTER_A = 2'b00,
      ENTER_B = 2'b01,
      CALC    = 2'b10,
      RESULT  = 2'b11
   } state_t;

   state_t              r_state;
   logic                r_press_d;
   logic                r_blk;
   logic [DIGITS-1:0]   r_flag_1, r_flag_2;
   logic [CW-1:0]       r_code_1, r_code_2;
   logic                r_op_sub, r_calc_req, r_result_valid, r_err;

   logic                w_key, w_is_digit, w_cur_b, w_cur_empty, w_cur_full;
   logic [DIGITS-1:0]   w_cur_flag, w_op_flag;
   logic [CW-1:0]       w_cur_code, w_op_code;
   logic                w_op_we;

   // r_blk holds off acceptance when the key was already down while reset was
   // asserted. The key must be released once before any edge counts.
   assign w_key      = i_press & ~r_press_d & ~r_blk;
   assign w_is_digit = (i_scan_code <= 4'd9);

   // The operand being edited: operand 2 only while in ENTER_B.
   assign w_cur_b     = (r_state == ENTER_B);
   assign w_cur_flag  = w_cur_b ? r_flag_2 : r_flag_1;
   assign w_cur_code  = w_cur_b ? r_code_2 : r_code_1;
   // The flags are a thermometer code, so the end bits give empty and full.
   assign w_cur_empty = ~w_cur_flag[0];
   assign w_cur_full  = w_cur_flag[DIGITS-1];

   // Buffer edits for the current operand in the entry states.
   always_comb begin
      w_op_we   = 1'b0;
      w_op_code = w_cur_code;
      w_op_flag = w_cur_flag;
      if (w_key && (r_state == ENTER_A || r_state == ENTER_B)) begin
         if (w_is_digit) begin
            // A leading zero is swallowed silently. A full buffer is rejected in the FSM.
            if (!w_cur_full && !(w_cur_empty && i_scan_code == 4'd0)) begin
               w_op_we   = 1'b1;
               w_op_code = {w_cur_code[CW-5:0], i_scan_code};
               w_op_flag = {w_cur_flag[DIGITS-2:0], 1'b1};
            end
         end else if (i_scan_code == KEY_BS) begin
            w_op_we   = ~w_cur_empty;
            w_op_code = w_cur_code >> 4;
            w_op_flag = w_cur_flag >> 1;
         end else if (i_scan_code == KEY_CE) begin
            w_op_we   = 1'b1;
            w_op_code = '0;
            w_op_flag = '0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= ENTER_A;
         r_press_d      <= 1'b0;
         r_blk          <= i_press;
         r_flag_1       <= '0;
         r_flag_2       <= '0;
         r_code_1       <= '0;
         r_code_2       <= '0;
         r_op_sub       <= 1'b0;
         r_calc_req     <= 1'b0;
         r_result_valid <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_press_d <= i_press;
         if (!i_press) r_blk <= 1'b0;
         r_err <= 1'b0;

         if (w_key && i_scan_code == KEY_AC) begin
            // All-clear overrides everything, including an ack on the same edge.
            r_flag_1       <= '0;
            r_flag_2       <= '0;
            r_code_1       <= '0;
            r_code_2       <= '0;
            r_op_sub       <= 1'b0;
            r_calc_req     <= 1'b0;
            r_result_valid <= 1'b0;
            r_state        <= ENTER_A;
         end else if (r_state == CALC) begin
            if (w_key) r_err <= 1'b1;
            if (i_calc_ack) begin
               r_calc_req     <= 1'b0;
               r_result_valid <= 1'b1;
               r_state        <= RESULT;
            end
         end else if (r_state == RESULT) begin
            if (w_key) begin
               // Any key leaves the display. A non-zero digit opens a new operand 1.
               r_result_valid <= 1'b0;
               r_state        <= ENTER_A;
               r_flag_1       <= '0;
               r_code_1       <= '0;
               r_flag_2       <= '0;
               r_code_2       <= '0;
               if (w_is_digit && i_scan_code != 4'd0) begin
                  r_code_1 <= CW'(i_scan_code);
                  r_flag_1 <= DIGITS'(1);
               end
               if (i_scan_code == KEY_ADD || i_scan_code == KEY_SUB || i_scan_code == KEY_EQ)
                  r_err <= 1'b1;
            end
         end else if (w_key) begin
            if (w_op_we) begin
               if (w_cur_b) begin
                  r_code_2 <= w_op_code;
                  r_flag_2 <= w_op_flag;
               end else begin
                  r_code_1 <= w_op_code;
                  r_flag_1 <= w_op_flag;
               end
            end
            if (w_is_digit) begin
               if (w_cur_full) r_err <= 1'b1;
            end else begin
               case (i_scan_code)
                  KEY_ADD, KEY_SUB: begin
                     if (!w_cur_b) begin
                        r_op_sub <= (i_scan_code == KEY_SUB);
                        r_state  <= ENTER_B;
                     end else if (w_cur_empty) begin
                        r_op_sub <= (i_scan_code == KEY_SUB);
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
                  KEY_EQ: begin
                     if (w_cur_b) begin
                        r_state    <= CALC;
                        r_calc_req <= 1'b1;
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
                  KEY_BS: begin
                     // Backspace on an empty operand 2 steps back to operand 1.
                     if (w_cur_empty && w_cur_b) begin
                        r_state  <= ENTER_A;
                        r_op_sub <= 1'b0;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign o_buf_flag_1     = r_flag_1;
   assign o_key_buf_code_1 = r_code_1;
   assign o_buf_flag_2     = r_flag_2;
   assign o_key_buf_code_2 = r_code_2;
   assign o_op_sub         = r_op_sub;
   assign o_calc_req       = r_calc_req;
   assign o_result_valid   = r_result_valid;
   assign o_err            = r_err;
   assign o_state          = r_state;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl. A digit-queue reference model predicts every
// cycle's outputs. The predictions are queued, and a monitor compares them
// against the DUT one time unit after each rising edge.
module tb_calc_entry_ctrl;
   localparam int D = 6;

   bit          clk;
   logic        rst, press, calc_ack;
   logic [3:0]  scan_code;
   logic [D-1:0]   f1, f2;
   logic [4*D-1:0] c1, c2;
   logic        op_sub, calc_req, result_valid, err;
   logic [1:0]  state;

   always #5 clk = ~clk;

   calc_entry_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_press(press), .i_scan_code(scan_code), .i_calc_ack(calc_ack),
      .o_buf_flag_1(f1), .o_key_buf_code_1(c1), .o_buf_flag_2(f2), .o_key_buf_code_2(c2),
      .o_op_sub(op_sub), .o_calc_req(calc_req), .o_result_valid(result_valid), .o_err(err),
      .o_state(state)
   );

   typedef struct packed {
      logic [D-1:0]   f1;
      logic [4*D-1:0] c1;
      logic [D-1:0]   f2;
      logic [4*D-1:0] c2;
      logic           sub, req, rv, err;
      logic [1:0]     st;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0, errors = 0;

   // reference model: operands as digit lists (oldest first), state 0..3
   int  ops[2][$];
   int  m_st;
   bit  m_sub, m_req, m_rv, m_err, m_prev;
   int  ack_dly = 3, calc_cnt = 0;
   bit  force_ack = 0, rand_ack = 0;

   function automatic obs_t m_view();
      obs_t o;
      o = '0;
      for (int k = 0; k < ops[0].size(); k++) o.c1 = (o.c1 << 4) | (4*D)'(ops[0][k]);
      for (int k = 0; k < ops[1].size(); k++) o.c2 = (o.c2 << 4) | (4*D)'(ops[1][k]);
      o.f1  = D'((1 << ops[0].size()) - 1);
      o.f2  = D'((1 << ops[1].size()) - 1);
      o.sub = m_sub; o.req = m_req; o.rv = m_rv; o.err = m_err;
      o.st  = 2'(m_st);
      return o;
   endfunction

   task automatic model_step();
      bit k;
      int c, i;
      if (rst) begin
         ops[0].delete(); ops[1].delete();
         m_st = 0; m_sub = 0; m_req = 0; m_rv = 0; m_err = 0;
         m_prev = press;
         return;
      end
      k = press && !m_prev;
      m_prev = press;
      c = int'(scan_code);
      m_err = 0;
      if (k && c == 15) begin
         ops[0].delete(); ops[1].delete();
         m_st = 0; m_sub = 0; m_req = 0; m_rv = 0;
      end else if (m_st == 2) begin
         if (k) m_err = 1;
         if (calc_ack) begin m_req = 0; m_rv = 1; m_st = 3; end
      end else if (k && m_st == 3) begin
         ops[0].delete(); ops[1].delete();
         m_rv = 0; m_st = 0;
         if (c >= 10 && c <= 12) m_err = 1;
         else if (c >= 1 && c <= 9) ops[0].push_back(c);
      end else if (k) begin
         i = m_st;
         if (c <= 9) begin
            if (ops[i].size() == D) m_err = 1;
            else if (!(ops[i].size() == 0 && c == 0)) ops[i].push_back(c);
         end else if (c == 10 || c == 11) begin
            if (i == 0) begin m_sub = (c == 11); m_st = 1; end
            else if (ops[1].size() == 0) m_sub = (c == 11);
            else m_err = 1;
         end else if (c == 12) begin
            if (i == 1) begin m_st = 2; m_req = 1; end
            else m_err = 1;
         end else if (c == 13) begin
            if (ops[i].size() > 0) void'(ops[i].pop_back());
            else if (i == 1) begin m_st = 0; m_sub = 0; end
         end else if (c == 14) begin
            ops[i].delete();
         end
      end
   endtask

   // One cycle. Inputs are already set at the negedge; predict the post-edge outputs.
   task automatic tick();
      if (m_st == 2) begin
         calc_cnt++;
         calc_ack = force_ack || (calc_cnt >= ack_dly);
      end else begin
         calc_cnt = 0;
         calc_ack = force_ack || (rand_ack && $urandom_range(0, 5) == 0);
      end
      model_step();
      exp_q.push_back(m_view());
      @(negedge clk);
   endtask

   task automatic key(input logic [3:0] c, input int hold = 1, input int gap = 1);
      press = 1'b1; scan_code = c;
      repeat (hold) tick();
      press = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_calc();
      for (int n = 0; n < 60 && m_st == 2; n++) tick();
   endtask

   // monitor
   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {f1, c1, f2, c2, op_sub, calc_req, result_valid, err, state};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs @%0t: got st=%0d f1=%b c1=%h f2=%b c2=%h sub=%b req=%b rv=%b err=%b, expected st=%0d f1=%b c1=%h f2=%b c2=%h sub=%b req=%b rv=%b err=%b",
                        $time, a.st, a.f1, a.c1, a.f2, a.c2, a.sub, a.req, a.rv, a.err,
                        e.st, e.f1, e.c1, e.f2, e.c2, e.sub, e.req, e.rv, e.err);
            end
         end
      end
   end

   // stimulus
   initial begin
      int r;
      logic [3:0] c;
      rst = 1'b1; press = 1'b1; scan_code = 4'h7; calc_ack = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();           // key held across reset release: no accept
      press = 1'b0;
      tick();

      // basic add with a 3-cycle ack
      ack_dly = 3;
      key(4'h1); key(4'h2); key(4'h3); key(4'hA); key(4'h4); key(4'h5); key(4'hC);
      wait_calc(); repeat (2) tick();

      // leading zeros, full buffer
      key(4'hF);
      key(4'h0); key(4'h0); key(4'h7); key(4'h6); key(4'h5); key(4'h4); key(4'h3); key(4'h2); key(4'h1);

      // operator change and backspace back to operand 1
      key(4'hF); key(4'h9); key(4'hB); key(4'hD); key(4'hD); key(4'hD); key(4'hD);

      // long hold
      key(4'hF); key(4'h5, 20, 2);

      // all-clear while waiting for ack
      ack_dly = 1000;
      key(4'hF); key(4'h1); key(4'hA); key(4'h2); key(4'hC); tick(); key(4'hF);
      // all-clear on the same edge as ack
      key(4'h1); key(4'hA); key(4'h2); key(4'hC); tick();
      force_ack = 1'b1; press = 1'b1; scan_code = 4'hF; tick();
      force_ack = 1'b0; press = 1'b0; tick();

      // RESULT exits: digit, operator, backspace
      ack_dly = 2;
      key(4'h1); key(4'hB); key(4'h2); key(4'hC); wait_calc(); key(4'h8);
      key(4'hA); key(4'h3); key(4'hC); wait_calc(); key(4'hA);
      key(4'h4); key(4'hA); key(4'hC); wait_calc(); key(4'hD); key(4'hE);

      // random traffic, with stray acks outside CALC
      rand_ack = 1'b1;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         c = (r < 55) ? 4'(r % 10) : (r < 65) ? 4'hA : (r < 72) ? 4'hB : (r < 82) ? 4'hC :
             (r < 90) ? 4'hD : (r < 96) ? 4'hE : 4'hF;
         ack_dly = $urandom_range(1, 5);
         key(c, $urandom_range(1, 3), $urandom_range(1, 2));
      end

      @(posedge clk); #2;
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
